// File: rtl/reduction_frame_accum_pkg.sv
// reduction_frame_accum_pkg: shared widths, FSM states and result record
// for the frame reducer.
package reduction_frame_accum_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int CNT_W_DEF  = 8;
   localparam int CNT_MAX_W  = 32;

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   // beats is wide enough for any CNT_W up to CNT_MAX_W; the top narrows it
   typedef struct packed {
      logic                 f_and;
      logic                 f_or;
      logic                 f_nand;
      logic                 f_nor;
      logic                 f_xor;
      logic                 f_nxor;
      logic [CNT_MAX_W-1:0] beats;
      logic                 ovf;
   } result_t;

   localparam result_t RES_RST = '{f_and: 1'b0, f_or: 1'b0, f_nand: 1'b1, f_nor: 1'b1,
                                   f_xor: 1'b0, f_nxor: 1'b1, beats: '0, ovf: 1'b0};
endpackage

// File: rtl/reduction_dut.sv
// reduction_dut: combinational AND/OR/XOR reductions of one word, with
// their complements.
module reduction_dut #(
   parameter int W = 8
) (
   input  logic [W-1:0] in_data,
   output logic         out_and,
   output logic         out_nand,
   output logic         out_or,
   output logic         out_nor,
   output logic         out_xor,
   output logic         out_nxor
);
   assign out_and  = &in_data;
   assign out_nand = ~&in_data;
   assign out_or   = |in_data;
   assign out_nor  = ~|in_data;
   assign out_xor  = ^in_data;
   assign out_nxor = ~^in_data;
endmodule

// File: rtl/reduction_frame_accum.sv
// reduction_frame_accum: folds a valid/ready beat stream into AND/OR/XOR
// accumulators and presents frame-wide reduction flags when a frame closes.
module reduction_frame_accum
   import reduction_frame_accum_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_and,
   output logic              m_or,
   output logic              m_nand,
   output logic              m_nor,
   output logic              m_xor,
   output logic              m_nxor,
   output logic [CNT_W-1:0]  m_beats,
   output logic              m_ovf
);
   state_t              r_state;
   logic [DATA_W-1:0]   r_and, r_or, r_xor, w_and, w_or, w_xor;
   logic [CNT_W-1:0]    r_cnt, w_cnt;
   logic                r_ovf, w_ovf, w_acc, w_first, w_sat;
   logic                w_red_and, w_red_nand, w_red_or, w_red_nor, w_red_xor, w_red_nxor;
   logic [11:0]         w_unused_red;
   result_t             r_res;

   assign s_ready = rst_n && (r_state != HOLD || m_ready);
   assign w_acc   = s_valid && s_ready;
   assign w_first = r_state != ACCUM;
   assign w_sat   = &r_cnt;

   always_comb begin
      w_and = !w_acc ? r_and : w_first ? s_data : r_and & s_data;
      w_or  = !w_acc ? r_or  : w_first ? s_data : r_or  | s_data;
      w_xor = !w_acc ? r_xor : w_first ? s_data : r_xor ^ s_data;
      w_cnt = !w_acc ? r_cnt : w_first ? CNT_W'(1) : w_sat ? r_cnt : r_cnt + 1'b1;
      w_ovf = !w_acc ? r_ovf : w_first ? 1'b0 : r_ovf | w_sat;
   end

   // each stage contributes only the reduction matching its accumulator
   reduction_dut #(.W(DATA_W)) u_red_and (
      .in_data(w_and), .out_and(w_red_and), .out_nand(w_red_nand),
      .out_or(w_unused_red[0]), .out_nor(w_unused_red[1]),
      .out_xor(w_unused_red[2]), .out_nxor(w_unused_red[3]));
   reduction_dut #(.W(DATA_W)) u_red_or (
      .in_data(w_or), .out_and(w_unused_red[4]), .out_nand(w_unused_red[5]),
      .out_or(w_red_or), .out_nor(w_red_nor),
      .out_xor(w_unused_red[6]), .out_nxor(w_unused_red[7]));
   reduction_dut #(.W(DATA_W)) u_red_xor (
      .in_data(w_xor), .out_and(w_unused_red[8]), .out_nand(w_unused_red[9]),
      .out_or(w_unused_red[10]), .out_nor(w_unused_red[11]),
      .out_xor(w_red_xor), .out_nxor(w_red_nxor));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_and   <= '0;
         r_or    <= '0;
         r_xor   <= '0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
         r_res   <= RES_RST;
      end else begin
         r_and <= w_and;
         r_or  <= w_or;
         r_xor <= w_xor;
         r_cnt <= w_cnt;
         r_ovf <= w_ovf;
         if (w_acc && s_last) begin
            r_state <= HOLD;
            r_res   <= '{f_and: w_red_and, f_or: w_red_or, f_nand: w_red_nand,
                         f_nor: w_red_nor, f_xor: w_red_xor, f_nxor: w_red_nxor,
                         beats: CNT_MAX_W'(w_cnt), ovf: w_ovf};
         end else if (w_acc)
            r_state <= ACCUM;
         else if (r_state == HOLD && m_ready)
            r_state <= IDLE;
      end
   end

   assign m_valid = r_state == HOLD;
   assign m_and   = r_res.f_and;
   assign m_or    = r_res.f_or;
   assign m_nand  = r_res.f_nand;
   assign m_nor   = r_res.f_nor;
   assign m_xor   = r_res.f_xor;
   assign m_nxor  = r_res.f_nxor;
   assign m_beats = CNT_W'(r_res.beats);
   assign m_ovf   = r_res.ovf;
endmodule
